// File: rtl/game_pkg.sv
// Shared definitions for the balloon-scope game: tuning constants, round state
// encoding, overlay colours and a small population-count helper.
package game_pkg;

  localparam int N_TGT          = 4;
  localparam int AMMO_INIT      = 8;
  localparam int ROUND_TICKS    = 300;
  localparam int COOLDOWN_TICKS = 5;
  localparam int FLASH_TICKS    = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_WIN  = 2'd2,
    ST_OVER = 2'd3
  } game_state_e;

  // 12-bit RGB values consumed by the draw/colour mux.
  localparam logic [11:0] COL_SKY     = 12'h6AF;
  localparam logic [11:0] COL_BALLOON = 12'hF22;
  localparam logic [11:0] COL_FLASH   = 12'hFF8;

  function automatic logic [7:0] popcount(input logic [31:0] v);
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) n = n + 8'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/tick_down_cnt.sv
// Loadable down-counter advanced by the game tick; stops at zero and never wraps.
// Used for the round timer, the shot cooldown and the muzzle-flash window.
module tick_down_cnt #(
  parameter int           W       = 4,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_20,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] r_count;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_20 or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= RST_VAL;
    end else if (load) begin
      r_count <= load_val;
    end else if (tick && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign count = r_count;
  assign zero  = (r_count == '0);

endmodule

// File: rtl/game_round_ctrl.sv
// Round sequencer: gates fire edges into accepted shots, tracks ammo, score,
// popped balloons, round timer, cooldown and muzzle flash, and decides win/over.
module game_round_ctrl #(
  parameter int N_TGT          = game_pkg::N_TGT,
  parameter int AMMO_INIT      = game_pkg::AMMO_INIT,
  parameter int ROUND_TICKS    = game_pkg::ROUND_TICKS,
  parameter int COOLDOWN_TICKS = game_pkg::COOLDOWN_TICKS,
  parameter int FLASH_TICKS    = game_pkg::FLASH_TICKS
) (
  input  logic                             clk_20,
  input  logic                             rst_n,
  input  logic                             tick,
  input  logic                             start,
  input  logic                             fire_req,
  input  logic [N_TGT-1:0]                 hit_vec,
  output logic [1:0]                       state,
  output logic [$clog2(AMMO_INIT+1)-1:0]   ammo,
  output logic [7:0]                       score,
  output logic [$clog2(ROUND_TICKS+1)-1:0] time_left,
  output logic [N_TGT-1:0]                 hit_mask,
  output logic                             flash_en,
  output logic                             shot
);
  import game_pkg::*;

  localparam int AMMO_W = $clog2(AMMO_INIT + 1);
  localparam int TIME_W = $clog2(ROUND_TICKS + 1);
  localparam int CD_W   = $clog2(COOLDOWN_TICKS + 1);
  localparam int FL_W   = $clog2(FLASH_TICKS + 1);

  game_state_e       r_state;
  game_state_e       w_state_nxt;
  logic              r_start_prev, r_start_rise;
  logic              r_fire_prev, r_fire_rise;
  logic [AMMO_W-1:0] r_ammo;
  logic [7:0]        r_score;
  logic [N_TGT-1:0]  r_hit_mask;
  logic              r_shot;

  logic              w_play, w_reload, w_accept, w_tick_en;
  logic              w_time_zero, w_cd_zero, w_fl_zero;
  logic [TIME_W-1:0] w_time_count;
  logic [CD_W-1:0]   w_cd_count, w_cd_load_val;
  logic [FL_W-1:0]   w_fl_count, w_fl_load_val;
  logic [N_TGT-1:0]  w_new_hits;
  logic [8:0]        w_score_sum;
  logic              w_unused_cnt;

  assign w_play    = (r_state == ST_PLAY);
  assign w_reload  = r_start_rise && !w_play;
  assign w_accept  = w_play && r_fire_rise && (r_ammo != '0) && w_cd_zero;
  assign w_tick_en = w_play && tick;

  // Only balloons not already popped count towards the score.
  assign w_new_hits  = hit_vec & ~r_hit_mask;
  assign w_score_sum = {1'b0, r_score} + {1'b0, popcount(32'(w_new_hits))};

  // A fresh shot reloads the windows; a round (re)start clears them.
  assign w_cd_load_val = w_accept ? CD_W'(COOLDOWN_TICKS) : '0;
  assign w_fl_load_val = w_accept ? FL_W'(FLASH_TICKS) : '0;

  // Cooldown and flash are only needed as zero flags.
  assign w_unused_cnt = ^{w_cd_count, w_fl_count};

  tick_down_cnt #(.W(TIME_W), .RST_VAL(TIME_W'(ROUND_TICKS))) u_time_cnt (
    .clk_20(clk_20), .rst_n(rst_n), .load(w_reload), .load_val(TIME_W'(ROUND_TICKS)),
    .tick(w_tick_en), .count(w_time_count), .zero(w_time_zero)
  );

  tick_down_cnt #(.W(CD_W), .RST_VAL('0)) u_cooldown_cnt (
    .clk_20(clk_20), .rst_n(rst_n), .load(w_reload || w_accept), .load_val(w_cd_load_val),
    .tick(w_tick_en), .count(w_cd_count), .zero(w_cd_zero)
  );

  tick_down_cnt #(.W(FL_W), .RST_VAL('0)) u_flash_cnt (
    .clk_20(clk_20), .rst_n(rst_n), .load(w_reload || w_accept), .load_val(w_fl_load_val),
    .tick(w_tick_en), .count(w_fl_count), .zero(w_fl_zero)
  );

  always_ff @(posedge clk_20 or negedge rst_n) begin
    if (!rst_n) begin
      r_start_prev <= 1'b0;
      r_start_rise <= 1'b0;
      r_fire_prev  <= 1'b0;
      r_fire_rise  <= 1'b0;
    end else begin
      r_start_prev <= start;
      r_start_rise <= start && !r_start_prev;
      r_fire_prev  <= fire_req;
      r_fire_rise  <= fire_req && !r_fire_prev;
    end
  end

  always_ff @(posedge clk_20 or negedge rst_n) begin
    if (!rst_n) begin
      r_ammo     <= AMMO_W'(AMMO_INIT);
      r_score    <= '0;
      r_hit_mask <= '0;
      r_shot     <= 1'b0;
    end else begin
      r_shot <= w_accept;
      if (w_reload) begin
        r_ammo     <= AMMO_W'(AMMO_INIT);
        r_score    <= '0;
        r_hit_mask <= '0;
      end else if (w_accept) begin
        r_ammo     <= r_ammo - AMMO_W'(1);
        r_score    <= w_score_sum[8] ? 8'hFF : w_score_sum[7:0];
        r_hit_mask <= r_hit_mask | hit_vec;
      end
    end
  end

  always_ff @(posedge clk_20 or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves w_state_nxt unassigned (no latch).
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_WIN, ST_OVER: if (r_start_rise) w_state_nxt = ST_PLAY;
      ST_PLAY: begin
        if (&r_hit_mask)                      w_state_nxt = ST_WIN;
        else if (w_time_zero)                 w_state_nxt = ST_OVER;
        else if ((r_ammo == '0) && w_fl_zero) w_state_nxt = ST_OVER;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    state     = r_state;
    ammo      = r_ammo;
    score     = r_score;
    time_left = w_time_count;
    hit_mask  = r_hit_mask;
    shot      = r_shot;
    flash_en  = w_play && !w_fl_zero;
  end

endmodule

// File: tb/tb_game_round_ctrl.sv
// Self-checking bench for game_round_ctrl: directed table, multi-cycle corner
// sequences, then randomized stimulus against a behavioural round model.
module tb_game_round_ctrl;

  localparam int AMMO0   = 8;
  localparam int T_ROUND = 300;
  localparam int T_CD    = 5;
  localparam int T_FL    = 2;
  localparam int S_IDLE  = 0;
  localparam int S_PLAY  = 1;
  localparam int S_WIN   = 2;
  localparam int S_OVER  = 3;

  logic       clk_20   = 1'b0;
  logic       rst_n    = 1'b0;
  logic       tick     = 1'b0;
  logic       start    = 1'b0;
  logic       fire_req = 1'b0;
  logic [3:0] hit_vec  = 4'h0;
  logic [1:0] state;
  logic [3:0] ammo;
  logic [7:0] score;
  logic [8:0] time_left;
  logic [3:0] hit_mask;
  logic       flash_en;
  logic       shot;

  game_round_ctrl dut (
    .clk_20(clk_20), .rst_n(rst_n), .tick(tick), .start(start), .fire_req(fire_req),
    .hit_vec(hit_vec), .state(state), .ammo(ammo), .score(score), .time_left(time_left),
    .hit_mask(hit_mask), .flash_en(flash_en), .shot(shot)
  );

  always #5 clk_20 = ~clk_20;

  int n_checks = 0;
  int n_fail   = 0;
  int n_shots  = 0;

  // Behavioural round model, advanced once per clock with that cycle's inputs.
  int         m_state, m_ammo, m_score, m_time, m_cd, m_flash;
  logic [3:0] m_mask;
  bit         m_shot, m_fire_prev, m_fire_rise, m_start_prev, m_start_rise;

  typedef struct {
    bit         do_start;
    bit         do_fire;
    logic [3:0] hv;
    int         n_ticks;
    int         e_state;
    int         e_ammo;
    int         e_score;
    int         e_time;
    logic [3:0] e_mask;
    int         e_shots;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = S_IDLE; m_ammo = AMMO0; m_score = 0; m_time = T_ROUND;
    m_cd = 0; m_flash = 0; m_mask = 4'h0; m_shot = 1'b0;
    m_fire_prev = 1'b0; m_fire_rise = 1'b0; m_start_prev = 1'b0; m_start_rise = 1'b0;
  endtask

  task automatic model_step();
    bit play, acc;
    int nstate;
    play   = (m_state == S_PLAY);
    acc    = play && m_fire_rise && (m_ammo > 0) && (m_cd == 0);
    nstate = m_state;
    if (play) begin
      if (m_mask == 4'hF)                     nstate = S_WIN;
      else if (m_time == 0)                   nstate = S_OVER;
      else if ((m_ammo == 0) && (m_flash == 0)) nstate = S_OVER;
      if (tick) begin
        if (m_time > 0)  m_time--;
        if (m_cd > 0)    m_cd--;
        if (m_flash > 0) m_flash--;
      end
      if (acc) begin
        m_score = m_score + $countones(hit_vec & ~m_mask);
        if (m_score > 255) m_score = 255;
        m_mask  = m_mask | hit_vec;
        m_ammo  = m_ammo - 1;
        m_cd    = T_CD;
        m_flash = T_FL;
      end
    end else if (m_start_rise) begin
      nstate = S_PLAY;
      m_ammo = AMMO0; m_score = 0; m_time = T_ROUND; m_cd = 0; m_flash = 0; m_mask = 4'h0;
    end
    m_shot       = acc;
    m_fire_rise  = fire_req && !m_fire_prev;
    m_fire_prev  = fire_req;
    m_start_rise = start && !m_start_prev;
    m_start_prev = start;
    m_state      = nstate;
  endtask

  task automatic compare_model();
    check("rnd_state", state, m_state);
    check("rnd_ammo", ammo, m_ammo);
    check("rnd_score", score, m_score);
    check("rnd_time", time_left, m_time);
    check("rnd_mask", hit_mask, m_mask);
    check("rnd_flash", flash_en, ((m_state == S_PLAY) && (m_flash != 0)) ? 1 : 0);
    check("rnd_shot", shot, m_shot ? 1 : 0);
  endtask

  // One clock: inputs applied now, outputs settled at the following falling edge.
  task automatic cyc(input bit tk);
    tick = tk;
    model_step();
    @(negedge clk_20);
    tick = 1'b0;
    if (shot) n_shots++;
  endtask

  task automatic ticks(input int k);
    repeat (k) begin
      cyc(1'b1);
      cyc(1'b0);
    end
  endtask

  task automatic press_start();
    start = 1'b1; cyc(1'b0);
    start = 1'b0; cyc(1'b0);
  endtask

  task automatic fire_shot(input logic [3:0] hv);
    hit_vec = hv;
    fire_req = 1'b1; cyc(1'b0);
    fire_req = 1'b0; cyc(1'b0);
    hit_vec = 4'h0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; tick = 1'b0; start = 1'b0; fire_req = 1'b0; hit_vec = 4'h0;
    model_reset();
    repeat (2) @(negedge clk_20);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int shots0, fl_ticks;
    logic [3:0] seq_hv [7];

    tbl[0] = '{1'b1, 1'b0, 4'h0, 0, S_PLAY, 8, 0, 300, 4'h0, 0};
    tbl[1] = '{1'b0, 1'b1, 4'h1, 6, S_PLAY, 7, 1, 294, 4'h1, 1};
    tbl[2] = '{1'b0, 1'b1, 4'h2, 6, S_PLAY, 6, 2, 288, 4'h3, 2};
    tbl[3] = '{1'b0, 1'b1, 4'h0, 6, S_PLAY, 5, 2, 282, 4'h3, 3};
    tbl[4] = '{1'b1, 1'b0, 4'h0, 0, S_PLAY, 5, 2, 282, 4'h3, 3};
    tbl[5] = '{1'b0, 1'b1, 4'h3, 2, S_PLAY, 4, 2, 280, 4'h3, 4};
    tbl[6] = '{1'b0, 1'b1, 4'h4, 6, S_PLAY, 4, 2, 274, 4'h3, 4};
    tbl[7] = '{1'b0, 1'b1, 4'hC, 6, S_WIN,  3, 4, 273, 4'hF, 5};
    tbl[8] = '{1'b1, 1'b0, 4'h0, 0, S_PLAY, 8, 0, 300, 4'h0, 5};

    apply_reset();
    check("rst_state", state, S_IDLE);
    check("rst_ammo", ammo, AMMO0);
    check("rst_score", score, 0);
    check("rst_time", time_left, T_ROUND);
    check("rst_mask", hit_mask, 0);
    check("rst_flash", flash_en, 0);
    check("rst_shot", shot, 0);

    for (int i = 0; i < 9; i++) begin
      if (tbl[i].do_start) press_start();
      if (tbl[i].do_fire)  fire_shot(tbl[i].hv);
      ticks(tbl[i].n_ticks);
      cyc(1'b0);
      check($sformatf("tbl%0d_state", i), state, tbl[i].e_state);
      check($sformatf("tbl%0d_ammo", i), ammo, tbl[i].e_ammo);
      check($sformatf("tbl%0d_score", i), score, tbl[i].e_score);
      check($sformatf("tbl%0d_time", i), time_left, tbl[i].e_time);
      check($sformatf("tbl%0d_mask", i), hit_mask, tbl[i].e_mask);
      check($sformatf("tbl%0d_shots", i), n_shots, tbl[i].e_shots);
    end

    // Fire held for 50 ticks: one shot, flash lasts exactly FLASH_TICKS ticks.
    apply_reset();
    press_start();
    shots0 = n_shots;
    fire_req = 1'b1;
    cyc(1'b0);
    cyc(1'b0);
    check("hold_flash_on", flash_en, 1);
    fl_ticks = 0;
    for (int i = 0; i < 50; i++) begin
      if (flash_en) fl_ticks++;
      cyc(1'b1);
      cyc(1'b0);
    end
    fire_req = 1'b0;
    cyc(1'b0);
    check("hold_shots", n_shots - shots0, 1);
    check("hold_flash_ticks", fl_ticks, T_FL);
    check("hold_ammo", ammo, 7);
    check("hold_time", time_left, 250);

    // Last shot pops the last balloon: WIN takes priority over ammo exhaustion.
    apply_reset();
    press_start();
    seq_hv = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h0};
    for (int i = 0; i < 7; i++) begin
      fire_shot(seq_hv[i]);
      ticks(6);
    end
    check("last_pre_ammo", ammo, 1);
    check("last_pre_mask", hit_mask, 4'h7);
    fire_shot(4'h8);
    cyc(1'b0);
    check("last_state", state, S_WIN);
    check("last_ammo", ammo, 0);
    check("last_score", score, 4);
    check("last_mask", hit_mask, 4'hF);
    check("last_flash_forced", flash_en, 0);
    ticks(3);
    check("last_state_held", state, S_WIN);

    // Round timeout with no firing, then restart from OVER.
    press_start();
    check("tmo_reload_ammo", ammo, AMMO0);
    ticks(299);
    check("tmo_time_1", time_left, 1);
    check("tmo_still_play", state, S_PLAY);
    cyc(1'b1);
    check("tmo_time_0", time_left, 0);
    cyc(1'b0);
    check("tmo_state", state, S_OVER);
    ticks(2);
    check("tmo_time_floor", time_left, 0);
    press_start();
    check("rst_play_state", state, S_PLAY);
    check("rst_play_ammo", ammo, AMMO0);
    check("rst_play_score", score, 0);
    check("rst_play_time", time_left, T_ROUND);
    check("rst_play_mask", hit_mask, 0);

    // Asynchronous reset in the middle of a muzzle flash.
    fire_shot(4'h1);
    check("mid_flash_on", flash_en, 1);
    check("mid_shot_on", shot, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_state", state, S_IDLE);
    check("async_ammo", ammo, AMMO0);
    check("async_score", score, 0);
    check("async_time", time_left, T_ROUND);
    check("async_mask", hit_mask, 0);
    check("async_flash", flash_en, 0);
    check("async_shot", shot, 0);
    model_reset();
    @(negedge clk_20);
    rst_n = 1'b1;

    // Randomized stimulus against the round model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) start = ~start;
      if ($urandom_range(0, 2) == 0)  fire_req = ~fire_req;
      hit_vec = 4'($urandom_range(0, 15));
      cyc($urandom_range(0, 3) == 0);
      compare_model();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
